// File: rtl/circle_pkg.sv
// circle_pkg: shared state, octant types and constants for the circle rasteriser
package circle_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, INIT, OCT, SPAN, STEP, DONE} state_t;
    typedef logic [2:0] oct_t;
    localparam int BLANK_COLOUR = 0;
endpackage

// File: rtl/circle_if.sv
// circle_if: draw request, status and VGA pixel port of the circle engine
interface circle_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
);
    logic                start, clear_first, fill, busy, done, vga_plot;
    logic [COLOUR_W-1:0] colour, vga_colour;
    logic [X_W-1:0]      centre_x, vga_x;
    logic [Y_W-1:0]      centre_y, vga_y;
    logic [R_W-1:0]      radius;
    modport master (output start, clear_first, fill, colour, centre_x, centre_y, radius,
                    input busy, done, vga_x, vga_y, vga_colour, vga_plot);
    modport slave  (input start, clear_first, fill, colour, centre_x, centre_y, radius,
                    output busy, done, vga_x, vga_y, vga_colour, vga_plot);
endinterface

// File: rtl/circle_clip.sv
// circle_clip: screen-bounds test and truncation of a signed pixel coordinate
module circle_clip #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
) (
    input  logic signed [X_W+1:0] x,
    input  logic signed [Y_W+1:0] y,
    output logic                  in_range,
    output logic [X_W-1:0]        xt,
    output logic [Y_W-1:0]        yt
);
    localparam logic signed [X_W+1:0] X_LIM = (X_W+2)'(SCREEN_W);
    localparam logic signed [Y_W+1:0] Y_LIM = (Y_W+2)'(SCREEN_H);
    assign in_range = !x[X_W+1] && !y[Y_W+1] && x < X_LIM && y < Y_LIM;
    assign xt = x[X_W-1:0];
    assign yt = y[Y_W-1:0];
endmodule

// File: rtl/circle_engine.sv
// circle_engine: midpoint circle / filled disc rasteriser with optional screen pre-clear
module circle_engine import circle_pkg::*; #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
) (
    input logic     clk,
    input logic     rst_n,
    circle_if.slave bus
);
    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    state_t                state, state_n;
    oct_t                  oct;
    logic [X_W-1:0]        cx, clx, vx, xt;
    logic [Y_W-1:0]        cy, cly, vy, yt;
    logic [R_W-1:0]        rad, ox, oy, ox_s, oy_s;
    logic [COLOUR_W-1:0]   col, vcol;
    logic                  fil, busy, done, vplot, in_range, span_end, clear_end, crit_pos, more;
    logic signed [R_W+1:0] crit, crit_s, sx, hs, nh, ox_e, oy_e;
    logic signed [X_W+1:0] px, cxs, ao;
    logic signed [Y_W+1:0] py, cys, bo;

    assign clear_end = clx == X_LAST && cly == Y_LAST;
    assign crit_pos  = !crit[R_W+1] && crit != '0;
    assign oy_s      = oy + R_W'(1);
    assign ox_s      = crit_pos ? ox - R_W'(1) : ox;
    assign oy_e      = $signed((R_W+2)'(oy_s));
    assign ox_e      = $signed((R_W+2)'(ox_s));
    assign crit_s    = crit + (oy_e <<< 1) + (R_W+2)'(1) - (crit_pos ? (ox_e <<< 1) : (R_W+2)'(0));
    assign more      = oy_s <= ox_s;
    // span index lives in oct[1:0]; spans 0/1 are half-width ox, spans 2/3 half-width oy
    assign hs        = $signed((R_W+2)'(oct[1] ? oy : ox));
    assign nh        = $signed((R_W+2)'((oct[1] | oct[0]) ? oy : ox));
    assign span_end  = sx == hs;

    assign cxs = $signed((X_W+2)'(cx));
    assign cys = $signed((Y_W+2)'(cy));
    assign ao  = $signed((X_W+2)'(oct[0] ? oy : ox));
    assign bo  = $signed((Y_W+2)'((state == SPAN ? oct[1] : oct[0]) ? ox : oy));
    assign px  = state == SPAN ? cxs + (X_W+2)'(sx) : (oct[2] ^ oct[1]) ? cxs - ao : cxs + ao;
    assign py  = (state == SPAN ? oct[0] : oct[2]) ? cys - bo : cys + bo;

    circle_clip #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_W(X_W), .Y_W(Y_W)) u_clip (
        .x(px), .y(py), .in_range(in_range), .xt(xt), .yt(yt)
    );

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.vga_x      = vx;
    assign bus.vga_y      = vy;
    assign bus.vga_colour = vcol;
    assign bus.vga_plot   = vplot;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    // Next-state decision
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = bus.clear_first ? CLEAR : INIT;
            CLEAR:   if (clear_end) state_n = INIT;
            INIT:    state_n = fil ? SPAN : OCT;
            OCT:     if (oct == 3'd7) state_n = STEP;
            SPAN:    if (span_end && oct[1:0] == 2'd3) state_n = STEP;
            STEP:    state_n = more ? (fil ? SPAN : OCT) : DONE;
            DONE:    if (!bus.start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request latch, midpoint datapath and registered pixel/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx <= '0; cy <= '0; rad <= '0; col <= '0; fil <= 1'b0;
            ox <= '0; oy <= '0; crit <= '0; sx <= '0; oct <= '0; clx <= '0; cly <= '0;
            busy <= 1'b0; done <= 1'b0; vx <= '0; vy <= '0; vcol <= '0; vplot <= 1'b0;
        end else begin
            vplot <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    cx   <= bus.centre_x;
                    cy   <= bus.centre_y;
                    rad  <= bus.radius;
                    col  <= bus.colour;
                    fil  <= bus.fill;
                    busy <= 1'b1;
                    clx  <= '0;
                    cly  <= '0;
                end
                CLEAR: begin
                    vx    <= clx;
                    vy    <= cly;
                    vcol  <= COLOUR_W'(BLANK_COLOUR);
                    vplot <= 1'b1;
                    cly   <= cly == Y_LAST ? '0 : cly + Y_W'(1);
                    clx   <= cly == Y_LAST ? clx + X_W'(1) : clx;
                end
                INIT: begin
                    ox   <= rad;
                    oy   <= '0;
                    crit <= (R_W+2)'(1) - $signed((R_W+2)'(rad));
                    sx   <= -$signed((R_W+2)'(rad));
                    oct  <= '0;
                end
                OCT: begin
                    vx    <= xt;
                    vy    <= yt;
                    vcol  <= col;
                    vplot <= in_range;
                    oct   <= oct + 3'd1;
                end
                SPAN: begin
                    vx    <= xt;
                    vy    <= yt;
                    vcol  <= col;
                    vplot <= in_range;
                    oct   <= span_end ? oct + 3'd1 : oct;
                    sx    <= span_end ? -nh : sx + (R_W+2)'(1);
                end
                STEP: begin
                    oy   <= oy_s;
                    ox   <= ox_s;
                    crit <= crit_s;
                    sx   <= -ox_e;
                    oct  <= '0;
                    busy <= more;
                    done <= !more;
                end
                DONE: if (!bus.start) done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_circle_engine.sv
// tb_circle_engine: directed and randomized draws checked against a behavioural raster model
module tb_circle_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, errors = 0;
    int   exp_q[$], obs_q[$];
    int   exp_cycles, busy_cycles, stray;

    circle_if bus ();
    circle_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    function automatic int enc(input int x, input int y, input int c);
        return (x << 16) | (y << 8) | c;
    endfunction

    // One cycle of the raster: a pixel is expected only when it lands on the screen
    task automatic put(input int x, input int y, input int c);
        exp_cycles++;
        if (x >= 0 && x < 160 && y >= 0 && y < 120) exp_q.push_back(enc(x, y, c));
    endtask

    task automatic span(input int y, input int x0, input int x1, input int c);
        for (int x = x0; x <= x1; x++) put(x, y, c);
    endtask

    task automatic model(input int cx, input int cy, input int r, input int c, input int clr, input int fil);
        int ox = r, oy = 0, crit = 1 - r;
        exp_q.delete();
        exp_cycles = 1;
        if (clr != 0)
            for (int x = 0; x < 160; x++)
                for (int y = 0; y < 120; y++) put(x, y, 0);
        do begin
            if (fil != 0) begin
                span(cy + oy, cx - ox, cx + ox, c);
                span(cy - oy, cx - ox, cx + ox, c);
                span(cy + ox, cx - oy, cx + oy, c);
                span(cy - ox, cx - oy, cx + oy, c);
            end else begin
                put(cx + ox, cy + oy, c); put(cx + oy, cy + ox, c);
                put(cx - ox, cy + oy, c); put(cx - oy, cy + ox, c);
                put(cx - ox, cy - oy, c); put(cx - oy, cy - ox, c);
                put(cx + ox, cy - oy, c); put(cx + oy, cy - ox, c);
            end
            exp_cycles++;
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    task automatic draw(input string tag, input int cx, input int cy, input int r, input int c,
                        input int clr, input int fil, input int hold);
        int n = 0;
        obs_q.delete();
        busy_cycles = 0;
        stray = 0;
        model(cx, cy, r, c, clr, fil);
        @(negedge clk);
        bus.centre_x    = 8'(cx);
        bus.centre_y    = 7'(cy);
        bus.radius      = 8'(r);
        bus.colour      = 3'(c);
        bus.clear_first = clr[0];
        bus.fill        = fil[0];
        bus.start       = 1'b1;
        while (bus.done !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                bus.centre_x    = 8'($urandom);
                bus.centre_y    = 7'($urandom);
                bus.radius      = 8'($urandom);
                bus.colour      = 3'($urandom);
                bus.clear_first = 1'($urandom);
                bus.fill        = 1'($urandom);
            end
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.vga_plot === 1'b1) begin
                if (bus.busy === 1'b1) obs_q.push_back(enc(bus.vga_x, bus.vga_y, bus.vga_colour));
                else stray++;
            end
        end
        check({tag, "_timeout"}, n < 40000, 1);
        check({tag, "_cycles"}, busy_cycles, exp_cycles);
        check({tag, "_plots"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_pixel"}, obs_q[i], exp_q[i]);
            if (obs_q[i] != exp_q[i]) break;
        end
        check({tag, "_stray"}, stray, 0);
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_done_held"}, bus.done, 1);
            check({tag, "_plot_done"}, bus.vga_plot, 0);
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_done_drop"}, bus.done, 0);
        check({tag, "_busy_idle"}, bus.busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_x"}, bus.vga_x, 0);
        check({tag, "_y"}, bus.vga_y, 0);
        check({tag, "_colour"}, bus.vga_colour, 0);
        check({tag, "_plot"}, bus.vga_plot, 0);
    endtask

    initial begin
        int t2x[8] = '{120, 80, 40, 80, 40, 80, 120, 80};
        int t2y[8] = '{60, 100, 60, 100, 60, 20, 60, 20};
        int fx[8]  = '{9, 10, 11, 9, 10, 11, 10, 10};
        int fy[8]  = '{10, 10, 10, 10, 10, 10, 11, 9};
        int bad, c1, x, y, d;
        bus.start = 1'b0; bus.clear_first = 1'b0; bus.fill = 1'b0;
        bus.colour = '0; bus.centre_x = '0; bus.centre_y = '0; bus.radius = '0;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("idle");

        draw("outline", 80, 60, 40, 2, 0, 0, 5);
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check("outline_first8", obs_q[i], enc(t2x[i], t2y[i], 2));
        bad = 0;
        foreach (obs_q[i]) begin
            x = obs_q[i] >> 16;
            y = (obs_q[i] >> 8) & 255;
            d = (x - 80) * (x - 80) + (y - 60) * (y - 60) - 1600;
            if (d > 80 || d < -80) bad++;
        end
        check("outline_ring", bad, 0);

        draw("clear", 80, 60, 40, 2, 1, 0, 0);
        if (obs_q.size() > 19207) begin
            check("clear_first", obs_q[0], enc(0, 0, 0));
            check("clear_last", obs_q[19199], enc(159, 119, 0));
            check("clear_then_circle", obs_q[19200], enc(120, 60, 2));
        end else check("clear_size", obs_q.size(), 19208);

        draw("clip", 2, 2, 10, 5, 0, 0, 0);
        c1 = busy_cycles;
        bad = 0;
        foreach (obs_q[i]) if ((obs_q[i] >> 16) >= 160 || ((obs_q[i] >> 8) & 255) >= 120) bad++;
        check("clip_offscreen", bad, 0);
        draw("clip_ref", 80, 60, 10, 5, 0, 0, 0);
        check("clip_same_cycles", c1, busy_cycles);

        draw("fill", 10, 10, 1, 7, 0, 1, 1);
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check("fill_first8", obs_q[i], enc(fx[i], fy[i], 7));
        bad = 0;
        foreach (obs_q[i]) begin
            x = (obs_q[i] >> 16) - 10;
            y = ((obs_q[i] >> 8) & 255) - 10;
            if (x * x + y * y > 2) bad++;
        end
        check("fill_in_disc", bad, 0);

        @(negedge clk);
        bus.centre_x = 8'd80; bus.centre_y = 7'd60; bus.radius = 8'd40;
        bus.colour = 3'd2; bus.clear_first = 1'b1; bus.fill = 1'b0; bus.start = 1'b1;
        repeat (500) @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("abort");
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("abort_idle");
        draw("restart", 80, 60, 40, 2, 1, 0, 0);

        for (int k = 0; k < 6; k++)
            draw("rand", $urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 20),
                 $urandom_range(0, 7), 0, $urandom_range(0, 1), $urandom_range(0, 3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
